sram_stream_ctrl: RTL

- Streaming access controller sitting directly upstream of the 4096x32 byte-lane SRAM wrapper in the MAC engine.
- Write mode: accepts a valid/ready stream of 32-bit words and writes them to consecutive SRAM addresses.
- Read mode: issues consecutive SRAM reads, absorbs the SRAM's fixed read latency, and presents the four returned byte lanes as a valid/ready stream with full backpressure support.

---
 rtl/sram_stream_pkg.sv | 20 ++
 rtl/sram_stream_fifo.sv | 61 ++++++
 rtl/sram_stream_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sram_stream_pkg.sv
// Shared types and constants for the SRAM streaming controller.
// The read pipeline depth is derived from SRAM_RD_LAT in the controller.
package sram_stream_pkg;

  typedef enum logic {
    SRAM_WRITE = 1'b0,
    SRAM_READ  = 1'b1
  } sram_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } sram_state_e;

  localparam int unsigned SRAM_RD_LAT = 1;
  localparam int unsigned NUM_LANES   = 4;

endpackage

// File: rtl/sram_stream_fifo.sv
// FWFT FIFO with empty-bypass: a push into an empty FIFO is visible (and poppable) the same cycle.
// Latency 0 when empty, otherwise 1 entry per pop; push_vld_i must not be raised when full without a pop.
module sram_stream_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_vld_i,
  input  logic [WIDTH-1:0] push_dat_i,
  output logic             pop_vld_o,
  input  logic             pop_rdy_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             empty, bypass, do_wr, do_rd;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count_q == '0);
  assign pop_vld_o = !empty || push_vld_i;
  assign pop_dat_o = !empty ? mem_q[rd_ptr_q] : (push_vld_i ? push_dat_i : '0);
  assign bypass    = empty && push_vld_i && pop_rdy_i;
  assign do_wr     = push_vld_i && !bypass;
  assign do_rd     = pop_vld_o && pop_rdy_i && !bypass;
  assign count_o   = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_rd) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr && !clear_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/sram_stream_ctrl.sv
// Streams words into / out of a byte-lane SRAM; strobes are registered, read data returns 2 cycles after issue.
// Write side is ready every WRITE cycle; reads are throttled so buffered plus in-flight words never exceed FIFO_DEPTH.
module sram_stream_ctrl
  import sram_stream_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LANE_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   num_words_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              sram_ceb_o,
  output logic              sram_web_o,
  output logic [ADDR_W-1:0] sram_a_o,
  output logic [DATA_W-1:0] sram_d_o,
  input  logic [LANE_W-1:0] sram_q0_i,
  input  logic [LANE_W-1:0] sram_q1_i,
  input  logic [LANE_W-1:0] sram_q2_i,
  input  logic [LANE_W-1:0] sram_q3_i
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PIPE_W = SRAM_RD_LAT + 1;

  sram_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic              done_q, done_d;
  logic              ceb_q, ceb_d, web_q, web_d;
  logic [ADDR_W-1:0] sram_a_q, sram_a_d;
  logic [DATA_W-1:0] sram_d_q, sram_d_d;
  // bit 0 is set in a read's strobe cycle, the MSB in the cycle its data is on the q lanes
  logic [PIPE_W-1:0] pipe_q, pipe_d;

  logic              wr_hs, issue_rd, pop_hs;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W:0]    occupancy;
  logic [DATA_W-1:0] ret_dat;
  logic [LANE_W-1:0] lanes [NUM_LANES];

  // q0 carries the word's top byte, so lanes are reassembled MSB-first to return the stored word
  assign lanes[0] = sram_q0_i;
  assign lanes[1] = sram_q1_i;
  assign lanes[2] = sram_q2_i;
  assign lanes[3] = sram_q3_i;
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign ret_dat[DATA_W-1-k*LANE_W -: LANE_W] = lanes[k];
  end

  always_comb begin
    occupancy = (CNT_W+1)'(fifo_cnt);
    for (int i = 0; i < PIPE_W; i++) occupancy = occupancy + (CNT_W+1)'(pipe_q[i]);
  end

  assign pop_hs   = rd_valid_o && rd_ready_i;
  assign wr_hs    = !clear_i && (state_q == ST_WRITE) && wr_valid_i;
  assign issue_rd = !clear_i && (state_q == ST_READ) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign pipe_d   = clear_i ? '0 : {pipe_q[PIPE_W-2:0], issue_rd};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    ceb_d    = 1'b1;
    web_d    = 1'b1;
    sram_a_d = sram_a_q;
    sram_d_d = sram_d_q;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (num_words_i == '0) begin
              done_d = 1'b1;
            end else begin
              addr_d   = base_addr_i;
              remain_d = num_words_i;
              state_d  = (sram_mode_e'(mode_i) == SRAM_READ) ? ST_READ : ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (wr_hs) begin
            ceb_d    = 1'b0;
            web_d    = 1'b0;
            sram_a_d = addr_q;
            sram_d_d = wr_data_i;
            addr_d   = addr_q + 1'b1;
            remain_d = remain_q - 1'b1;
            if (remain_q == (ADDR_W+1)'(1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        ST_READ: begin
          if (issue_rd) begin
            ceb_d    = 1'b0;
            sram_a_d = addr_q;
            addr_d   = addr_q + 1'b1;
            remain_d = remain_q - 1'b1;
            if (remain_q == (ADDR_W+1)'(1)) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop_hs && (occupancy == (CNT_W+1)'(1))) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      done_q   <= 1'b0;
      ceb_q    <= 1'b1;
      web_q    <= 1'b1;
      sram_a_q <= '0;
      sram_d_q <= '0;
      pipe_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      done_q   <= done_d;
      ceb_q    <= ceb_d;
      web_q    <= web_d;
      sram_a_q <= sram_a_d;
      sram_d_q <= sram_d_d;
      pipe_q   <= pipe_d;
    end
  end

  sram_stream_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .push_vld_i (pipe_q[PIPE_W-1]),
    .push_dat_i (ret_dat),
    .pop_vld_o  (rd_valid_o),
    .pop_rdy_i  (rd_ready_i),
    .pop_dat_o  (rd_data_o),
    .count_o    (fifo_cnt)
  );

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign wr_ready_o = (state_q == ST_WRITE);
  assign sram_ceb_o = ceb_q;
  assign sram_web_o = web_q;
  assign sram_a_o   = sram_a_q;
  assign sram_d_o   = sram_d_q;

endmodule
